// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: multiplicand, accumulator/multiplier shifter, shift counter, product.
// Build macro MULT_DP_PROD_HOLD_EN: product registered on Done and held; otherwise prod taps the accumulator.
module mult_datapath #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Load,
  input  logic           Ad,
  input  logic           Sh,
  input  logic           Done,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           M,
  output logic           K,
  output logic [2*N-1:0] prod,
  output logic           prod_vld
);
  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [N-1:0]  b;
  logic [2*N:0]  acc;
  logic [CW-1:0] cnt;

  logic [N:0]    sum;
  logic [2*N:0]  acc_add;
  logic [2*N:0]  acc_nxt;
  logic [CW-1:0] cnt_nxt;

  // Upper half plus multiplicand; the (N+1)-th bit becomes the carry at acc[2N].
  assign sum     = {1'b0, acc[2*N-1:N]} + {1'b0, b};
  assign acc_add = {sum, acc[N-1:0]};

  // Ad and Sh together add first, then shift the summed word in the same edge.
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    if (Load) begin
      acc_nxt = {{(N+1){1'b0}}, mplier};
      cnt_nxt = '0;
    end else begin
      if (Ad) acc_nxt = acc_add;
      if (Sh) begin
        acc_nxt = {1'b0, acc_nxt[2*N:1]};
        cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b        <= '0;
      acc      <= '0;
      cnt      <= '0;
      prod_vld <= 1'b0;
    end else begin
      if (Load) b <= mcand;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      prod_vld <= Done;
    end
  end

  assign M = acc[0];
  assign K = (cnt == CNT_LAST);

`ifdef MULT_DP_PROD_HOLD_EN
  logic [2*N-1:0] prod_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      prod_q <= '0;
    else if (Done) prod_q <= acc[2*N-1:0];
  end

  assign prod = prod_q;
`else
  // Valid from the cycle after Done until the accumulator is next touched.
  assign prod = acc[2*N-1:0];
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: acts as the control FSM for N=4 and N=8 instances,
// products scoreboarded against a queue of expected values.
module tb_mult_datapath;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld, ad, sh, dn;
  logic        sel;
  logic [7:0]  mc, mp;

  logic        m4, k4, pv4;
  logic [7:0]  p4;
  logic        m8, k8, pv8;
  logic [15:0] p8;

  logic        M, K, pv;
  logic [15:0] prod;

  int tests = 0;
  int fails = 0;
  int q[$];
  int last_p[2];

  always #5 clk = ~clk;

  mult_datapath #(.N(4)) dut4 (
    .clk(clk), .rst(rst),
    .Load(ld & ~sel), .Ad(ad & ~sel), .Sh(sh & ~sel), .Done(dn & ~sel),
    .mcand(mc[3:0]), .mplier(mp[3:0]),
    .M(m4), .K(k4), .prod(p4), .prod_vld(pv4)
  );

  mult_datapath #(.N(8)) dut8 (
    .clk(clk), .rst(rst),
    .Load(ld & sel), .Ad(ad & sel), .Sh(sh & sel), .Done(dn & sel),
    .mcand(mc), .mplier(mp),
    .M(m8), .K(k8), .prod(p8), .prod_vld(pv8)
  );

  assign M    = sel ? m8  : m4;
  assign K    = sel ? k8  : k4;
  assign pv   = sel ? pv8 : pv4;
  assign prod = sel ? p8  : {8'h00, p4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive controls, let the rising edge take them, return at the falling edge.
  task automatic cyc(input logic l, input logic a, input logic s, input logic d);
    ld = l; ad = a; sh = s; dn = d;
    @(negedge clk);
    ld = 1'b0; ad = 1'b0; sh = 1'b0; dn = 1'b0;
  endtask

  // Issue Done and pop the scoreboard when prod_vld shows up (bounded wait).
  task automatic collect(input int exp);
    bit got;
    int e;
    got = 1'b0;
    q.push_back(exp);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 3 && !got; w++) begin
      if (pv) begin
        got = 1'b1;
        chk("prod_vld_latency", w, 0);
        e = q.pop_front();
        chk("prod", {16'h0, prod}, e);
        last_p[sel] = e;
      end else begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    if (!got) begin
      chk("prod_vld_timeout", 0, 1);
      q.delete();
    end else begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("prod_vld_pulse", pv, 0);
    end
  endtask

  // Full FSM sequence: Load, N x {Ad-if-M, Sh}, Done.
  task automatic run_mult(input logic s, input int a, input int b_op, input int exp, input int carry_it);
    int n;
    logic bitv;
    n   = s ? 8 : 4;
    sel = s;
    mc  = a[7:0];
    mp  = b_op[7:0];
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      bitv = mp[i];
      chk("M_decision", M, bitv);
      chk("K_decision", K, (i == n-1));
`ifdef MULT_DP_PROD_HOLD_EN
      chk("prod_hold", {16'h0, prod}, last_p[s]);
`endif
      cyc(1'b0, bitv, 1'b0, 1'b0);
      if (i == carry_it) chk("carry_after_add", dut4.acc[8], 1);
      chk("K_shift", K, (i == n-1));
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("K_after_last", K, 0);
    if (carry_it >= 0) chk("carry_at_done", dut4.acc[8], 0);
    collect(exp);
  endtask

  typedef struct {
    logic s;
    int   a;
    int   b;
    int   exp;
    int   carry_it;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 13,  11,  143,   -1};
    vecs[1] = '{1'b0, 15,  15,  225,    1};
    vecs[2] = '{1'b0, 0,   9,   0,     -1};
    vecs[3] = '{1'b1, 255, 255, 65025, -1};
    vecs[4] = '{1'b1, 1,   200, 200,   -1};

    rst = 1'b0; ld = 0; ad = 0; sh = 0; dn = 0; sel = 0; mc = 0; mp = 0;
    last_p[0] = 0; last_p[1] = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("reset_M", M, 0);
      chk("reset_K", K, 0);
      chk("reset_prod", {16'h0, prod}, 0);
      chk("reset_prod_vld", pv, 0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_mult(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].carry_it);

    // Async reset partway through 6x7, after the second shift.
    sel = 1'b0; mc = 8'd6; mp = 8'd7;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("pre_reset_M", M, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_M", M, 0);
    chk("midrst_K", K, 0);
    chk("midrst_prod", {16'h0, prod}, 0);
    chk("midrst_prod_vld", pv, 0);
    @(negedge clk);
    rst = 1'b1;
    last_p[0] = 0; last_p[1] = 0;
    @(negedge clk);
    run_mult(1'b0, 6, 7, 42, -1);

    // Re-Load mid-operation: 5x5 abandoned after its first shift, then 3x4.
    sel = 1'b0; mc = 8'd5; mp = 8'd5;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef MULT_DP_PROD_HOLD_EN
    chk("reload_prod_hold", {16'h0, prod}, 42);
`endif
    run_mult(1'b0, 3, 4, 12, -1);

    // Counter wrap: five shifts from a fresh Load, K only when cnt==3.
    sel = 1'b0; mc = 8'd1; mp = 8'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      chk("wrap_K", K, (j % 4 == 3));
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_K_end", K, 0);

    // Ad+Sh in one edge: upper 0, B=3, low 0001 -> (0x31)>>1 = 0x18.
    sel = 1'b0; mc = 8'd3; mp = 8'd1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("adsh_acc", {23'h0, dut4.acc}, 32'h18);
    chk("adsh_M", M, 0);
    collect(32'h18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
